// File: rtl/scan_pkg.sv
// Shared types and helpers for the wide configuration scan chain.
package scan_pkg;

  // One command per cycle, resolved by priority from the raw scan controls.
  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_SHIFT,
    CMD_CAPTURE,
    CMD_UPDATE
  } scan_cmd_e;

  // Width of the shift counter that tracks position inside a frame of n/w words.
  function automatic int scan_cnt_width(input int n, input int w);
    int words;
    words = n / w;
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

  // Capture beats shift, and shift beats update. An update is only a real
  // command when nothing else is requested in the same cycle.
  function automatic scan_cmd_e decode_cmd(input logic capture,
                                           input logic shift_en,
                                           input logic update);
    scan_cmd_e cmd;
    cmd = CMD_NONE;
    if (capture) begin
      cmd = CMD_CAPTURE;
    end else if (shift_en) begin
      cmd = CMD_SHIFT;
    end else if (update) begin
      cmd = CMD_UPDATE;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/scan_frame_counter.sv
// Modulo-WORDS counter with a combinational wrap flag, usable by any chain
// that needs to know where it is inside a frame.
module scan_frame_counter #(
  parameter int WORDS = 16,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  // A step on the last word of the frame completes it.
  always_comb begin
    wrap = step && (cnt == LAST);
  end

  // Clear has priority so a reload always realigns the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (step) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_chain_wide.sv
// Multi-lane configuration scan chain: W-lane shift register with capture
// path, frame alignment tracking and a shadow register that only changes on
// an aligned update.
module scan_chain_wide
  import scan_pkg::*;
#(
  parameter int N = 64,
  parameter int W = 4
) (
  input  logic         scan_clk,
  input  logic         scan_rst,
  input  logic [N-1:0] rst_din,
  input  logic         scan_en,
  input  logic [W-1:0] scan_in,
  output logic [W-1:0] scan_out,
  input  logic         scan_capture,
  input  logic [N-1:0] capture_din,
  input  logic         scan_update,
  output logic [N-1:0] dout,
  output logic         frame_done,
  output logic         update_err
);

  localparam int WORDS = N / W;
  localparam int CW    = scan_cnt_width(N, W);

  // Refuse to build a chain whose length is not a whole number of words.
  generate
    if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_params
      $error("scan_chain_wide: N must be a positive multiple of W");
    end
  endgenerate

  scan_cmd_e     cmd;
  logic [N-1:0]  sr;
  logic [N-1:0]  sr_shifted;
  logic [CW-1:0] cnt;
  logic          wrap;

  // Resolve the raw controls into a single command for this cycle.
  always_comb begin
    cmd = decode_cmd(scan_capture, scan_en, scan_update);
  end

  // Next chain contents for a shift; a single-word chain just replaces itself.
  generate
    if (N == W) begin : g_one_word
      assign sr_shifted = scan_in;
    end else begin : g_multi_word
      assign sr_shifted = {sr[N-W-1:0], scan_in};
    end
  endgenerate

  scan_frame_counter #(
    .WORDS(WORDS),
    .CW   (CW)
  ) u_frame_counter (
    .clk  (scan_clk),
    .rst  (scan_rst),
    .clear(cmd == CMD_CAPTURE),
    .step (cmd == CMD_SHIFT),
    .cnt  (cnt),
    .wrap (wrap)
  );

  // Shift register and output word; capture reloads without touching scan_out.
  always_ff @(posedge scan_clk or posedge scan_rst) begin
    if (scan_rst) begin
      sr       <= rst_din;
      scan_out <= '0;
    end else begin
      case (cmd)
        CMD_CAPTURE: sr <= capture_din;
        CMD_SHIFT: begin
          sr       <= sr_shifted;
          scan_out <= sr[N-1:N-W];
        end
        default: ;
      endcase
    end
  end

  // Shadow register: only an aligned, stand-alone update applies new settings.
  always_ff @(posedge scan_clk or posedge scan_rst) begin
    if (scan_rst) begin
      dout <= rst_din;
    end else if ((cmd == CMD_UPDATE) && (cnt == '0)) begin
      dout <= sr;
    end
  end

  // Frame pulse and sticky error for updates that arrive mid-frame or collide with a shift.
  always_ff @(posedge scan_clk or posedge scan_rst) begin
    if (scan_rst) begin
      frame_done <= 1'b0;
      update_err <= 1'b0;
    end else begin
      frame_done <= (cmd == CMD_SHIFT) && wrap;
      if (((cmd == CMD_SHIFT) && scan_update) ||
          ((cmd == CMD_UPDATE) && (cnt != '0))) begin
        update_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scan_chain_wide.sv
// Randomised and directed bench for scan_chain_wide with a word-queue reference model.
module tb_scan_chain_wide;

  localparam int N     = 8;
  localparam int W     = 2;
  localparam int WORDS = N / W;

  typedef struct {
    logic [W-1:0] scan_out;
    logic [N-1:0] dout;
    logic         frame_done;
    logic         update_err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] rst_din = '0;
  logic         scan_en = 1'b0;
  logic [W-1:0] scan_in = '0;
  logic [W-1:0] scan_out;
  logic         scan_capture = 1'b0;
  logic [N-1:0] capture_din = '0;
  logic         scan_update = 1'b0;
  logic [N-1:0] dout;
  logic         frame_done;
  logic         update_err;

  int checks = 0;
  int errors = 0;

  // Reference model: the chain is a queue of words, index 0 being the top word.
  logic [W-1:0] m_words[$];
  logic [N-1:0] m_dout;
  logic [W-1:0] m_scan_out;
  int           m_shifts;
  logic         m_frame_done;
  logic         m_err;

  exp_t exp_q[$];

  scan_chain_wide #(.N(N), .W(W)) dut (
    .scan_clk    (clk),
    .scan_rst    (rst),
    .rst_din     (rst_din),
    .scan_en     (scan_en),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .scan_capture(scan_capture),
    .capture_din (capture_din),
    .scan_update (scan_update),
    .dout        (dout),
    .frame_done  (frame_done),
    .update_err  (update_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [N-1:0] actual,
                              input logic [N-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [N-1:0] model_value();
    logic [N-1:0] v;
    v = '0;
    foreach (m_words[i]) v = (v << W) | N'(m_words[i]);
    return v;
  endfunction

  task automatic model_load(input logic [N-1:0] v);
    m_words.delete();
    for (int i = 0; i < WORDS; i++) m_words.push_back(v[N-1-W*i -: W]);
  endtask

  task automatic model_reset(input logic [N-1:0] rv);
    model_load(rv);
    m_dout       = rv;
    m_scan_out   = '0;
    m_shifts     = 0;
    m_frame_done = 1'b0;
    m_err        = 1'b0;
  endtask

  task automatic model_step(input logic cap, input logic en, input logic upd,
                            input logic [W-1:0] din, input logic [N-1:0] cdin);
    m_frame_done = 1'b0;
    if (cap) begin
      model_load(cdin);
      m_shifts = 0;
    end else if (en) begin
      m_scan_out = m_words.pop_front();
      m_words.push_back(din);
      m_shifts = (m_shifts + 1) % WORDS;
      m_frame_done = (m_shifts == 0);
      if (upd) m_err = 1'b1;
    end else if (upd) begin
      if (m_shifts == 0) m_dout = model_value();
      else m_err = 1'b1;
    end
  endtask

  // Drive one cycle of controls, advance the model and queue what the DUT must show.
  task automatic apply_stimulus(input logic cap, input logic en, input logic upd,
                                input logic [W-1:0] din, input logic [N-1:0] cdin);
    exp_t e;
    @(negedge clk);
    scan_capture = cap;
    scan_en      = en;
    scan_update  = upd;
    scan_in      = din;
    capture_din  = cdin;
    @(posedge clk);
    #1;
    model_step(cap, en, upd, din, cdin);
    e.scan_out   = m_scan_out;
    e.dout       = m_dout;
    e.frame_done = m_frame_done;
    e.update_err = m_err;
    exp_q.push_back(e);
    scan_capture = 1'b0;
    scan_en      = 1'b0;
    scan_update  = 1'b0;
  endtask

  // Reset asserted between clock edges; outputs must reset without waiting for a clock.
  task automatic do_reset(input logic [N-1:0] rv);
    @(negedge clk);
    #2;
    rst_din = rv;
    rst     = 1'b1;
    #1;
    model_reset(rv);
    check_output("reset_dout", dout, rv);
    check_output("reset_scan_out", N'(scan_out), '0);
    check_output("reset_frame_done", N'(frame_done), '0);
    check_output("reset_update_err", N'(update_err), '0);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: compares every queued expectation against the registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("sb_scan_out", N'(scan_out), N'(e.scan_out));
        check_output("sb_dout", dout, e.dout);
        check_output("sb_frame_done", N'(frame_done), N'(e.frame_done));
        check_output("sb_update_err", N'(update_err), N'(e.update_err));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] saved;
    logic [1:0]   seq[4];

    // Reset and first shift exposes the top word of the reset value.
    do_reset(8'hA5);
    apply_stimulus(1'b0, 1'b1, 1'b0, 2'b01, '0);
    check_output("first_shift_out", N'(scan_out), N'(2'b10));

    // Aligned load of E4.
    do_reset(8'hA5);
    apply_stimulus(1'b0, 1'b1, 1'b0, 2'b11, '0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 2'b10, '0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 2'b01, '0);
    check_output("frame_done_early", N'(frame_done), '0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 2'b00, '0);
    check_output("frame_done_pulse", N'(frame_done), 1);
    apply_stimulus(1'b0, 1'b0, 1'b1, '0, '0);
    check_output("aligned_dout", dout, 8'hE4);
    check_output("aligned_err", N'(update_err), '0);

    // Misaligned update is rejected and latches the error.
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b0, W'($urandom), '0);
    apply_stimulus(1'b0, 1'b0, 1'b1, '0, '0);
    check_output("misaligned_dout", dout, 8'hE4);
    check_output("misaligned_err", N'(update_err), 1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 2'b10, '0);
    apply_stimulus(1'b0, 1'b0, 1'b1, '0, '0);
    check_output("realigned_dout", dout, model_value());
    check_output("err_sticky", N'(update_err), 1);

    // Capture readback of 3C, MSB word first.
    saved = m_dout;
    seq[0] = 2'b00; seq[1] = 2'b11; seq[2] = 2'b11; seq[3] = 2'b00;
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, 8'h3C);
    for (int i = 0; i < WORDS; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, W'($urandom), '0);
      check_output("readback_word", N'(scan_out), N'(seq[i]));
    end
    check_output("readback_dout", dout, saved);

    // Simultaneous commands.
    do_reset(8'h5A);
    apply_stimulus(1'b0, 1'b1, 1'b0, 2'b11, '0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 2'b01, 8'hC3);
    check_output("all_cmd_dout", dout, 8'h5A);
    check_output("all_cmd_err", N'(update_err), '0);
    for (int i = 0; i < WORDS; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 2'b00, '0);
    check_output("capture_realigns", N'(frame_done), 1);
    apply_stimulus(1'b0, 1'b1, 1'b1, 2'b10, '0);
    check_output("shift_update_err", N'(update_err), 1);
    check_output("shift_update_dout", dout, 8'h5A);

    // Reset mid-frame, then a clean frame.
    do_reset(8'h96);
    apply_stimulus(1'b0, 1'b1, 1'b0, 2'b01, '0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 2'b10, '0);
    do_reset(8'h96);
    for (int i = 0; i < WORDS; i++) apply_stimulus(1'b0, 1'b1, 1'b0, W'($urandom), '0);
    check_output("post_reset_frame", N'(frame_done), 1);

    // Random traffic with occasional resets to a random value.
    for (int i = 0; i < 600; i++) begin
      if ((i % 97) == 0) do_reset(N'($urandom));
      apply_stimulus($urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0,
                     $urandom_range(0, 3) == 0, W'($urandom), N'($urandom));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
